// File: rtl/pipe_operand_feeder_if.sv
// Operand feeder bus: operand intake, drive to and return from the arithmetic pipeline, result output.
interface pipe_operand_feeder_if #(parameter int N = 10);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_c;
  logic [N-1:0] in_d;
  logic [N-1:0] p_a;
  logic [N-1:0] p_b;
  logic [N-1:0] p_c;
  logic [N-1:0] p_d;
  logic [N-1:0] p_f;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         busy;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, p_f, res_ready,
    output in_ready, p_a, p_b, p_c, p_d, res_valid, res_data, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, p_f, res_ready,
    input  in_ready, p_a, p_b, p_c, p_d, res_valid, res_data, busy
  );
endinterface

// File: rtl/pipe_operand_feeder.sv
// Issue stage for a stall-free LAT-deep pipeline: buffers operand sets, issues one per cycle, captures F in order.
// Accept-to-result is LAT+2 edges when idle; issue is gated by result-FIFO credits, so res_ready=0 backs up into in_ready.
module pipe_operand_feeder #(
  parameter int N      = 10,
  parameter int IDEPTH = 4,
  parameter int RDEPTH = 4,
  parameter int LAT    = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  pipe_operand_feeder_if.slave io_bus
);
  localparam int IAW = $clog2(IDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int CW  = $clog2(RDEPTH + 1);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
  } opset_t;

  opset_t       r_imem [IDEPTH];
  logic [IAW:0] r_iwr;
  logic [IAW:0] r_ird;
  logic [N-1:0] r_rmem [RDEPTH];
  logic [RAW:0] r_rwr;
  logic [RAW:0] r_rrd;
  logic [LAT:0] r_tag;
  logic [CW-1:0] r_credits;
  opset_t       r_p;

  opset_t       w_in_dat;
  opset_t       w_ihead;
  logic [IAW:0] w_icount;
  logic [RAW:0] w_rcount;
  logic         w_ifull;
  logic         w_iempty;
  logic         w_rempty;
  logic         w_ipush;
  logic         w_issue;
  logic         w_rpush;
  logic         w_rpop;

  assign w_in_dat = {io_bus.in_a, io_bus.in_b, io_bus.in_c, io_bus.in_d};
  assign w_icount = r_iwr - r_ird;
  assign w_ifull  = (w_icount == (IAW+1)'(IDEPTH));
  assign w_iempty = (w_icount == '0);
  assign w_ihead  = r_imem[r_ird[IAW-1:0]];
  assign w_rcount = r_rwr - r_rrd;
  assign w_rempty = (w_rcount == '0);

  // in_ready is held low throughout reset and ignores a same-cycle pop
  assign io_bus.in_ready = i_rst_n && !w_ifull;
  assign w_ipush = io_bus.in_valid && io_bus.in_ready;
  assign w_issue = !w_iempty && (r_credits != '0);
  assign w_rpush = r_tag[LAT];
  assign w_rpop  = io_bus.res_valid && io_bus.res_ready;

  assign io_bus.p_a       = r_p.a;
  assign io_bus.p_b       = r_p.b;
  assign io_bus.p_c       = r_p.c;
  assign io_bus.p_d       = r_p.d;
  assign io_bus.res_valid = !w_rempty;
  assign io_bus.res_data  = w_rempty ? '0 : r_rmem[r_rrd[RAW-1:0]];
  assign io_bus.busy      = !w_iempty || !w_rempty || (|r_tag);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_iwr     <= '0;
      r_ird     <= '0;
      r_rwr     <= '0;
      r_rrd     <= '0;
      r_tag     <= '0;
      r_credits <= CW'(RDEPTH);
      r_p       <= '0;
    end else begin
      if (w_ipush) r_iwr <= r_iwr + (IAW+1)'(1);
      if (w_issue) begin
        r_ird <= r_ird + (IAW+1)'(1);
        r_p   <= w_ihead;
      end
      r_tag <= {r_tag[LAT-1:0], w_issue};
      // A credit held from issue to pop guarantees this push never overflows
      if (w_rpush) r_rwr <= r_rwr + (RAW+1)'(1);
      if (w_rpop)  r_rrd <= r_rrd + (RAW+1)'(1);
      case ({w_issue, w_rpop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ipush) r_imem[r_iwr[IAW-1:0]] <= w_in_dat;
    if (w_rpush) r_rmem[r_rwr[RAW-1:0]] <= io_bus.p_f;
  end
endmodule

// File: tb/tb_pipe_operand_feeder.sv
// Bench for pipe_operand_feeder: models the external 3-stage pipeline and scoreboards results in acceptance order.
module tb_pipe_operand_feeder;
  localparam int N      = 10;
  localparam int IDEPTH = 4;
  localparam int RDEPTH = 4;
  localparam int LAT    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [N-1:0] exp_q [$];

  bit           st_acc;
  bit           st_pop;
  logic [N-1:0] st_got;
  logic [N-1:0] st_exp;

  pipe_operand_feeder_if #(.N(N)) bus ();

  pipe_operand_feeder #(.N(N), .IDEPTH(IDEPTH), .RDEPTH(RDEPTH), .LAT(LAT)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  // External pipeline: A..D captured, then two more stages; never reset
  logic [N-1:0] s1_sum, s1_dif, s1_d, s2_sum, s2_d, s3_f;
  always @(posedge clk) begin
    s1_sum <= bus.p_a + bus.p_b;
    s1_dif <= bus.p_c - bus.p_d;
    s1_d   <= bus.p_d;
    s2_sum <= s1_sum + s1_dif;
    s2_d   <= s1_d;
    s3_f   <= s2_sum * s2_d;
  end
  assign bus.p_f = s3_f;

  function automatic logic [N-1:0] model(input logic [N-1:0] a, b, c, d);
    logic [N-1:0] s;
    logic [N-1:0] t;
    s = a + b;
    t = c - d;
    s = s + t;
    return N'(s * d);
  endfunction

  task automatic drive_set(input logic [N-1:0] a, b, c, d);
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d;
    bus.in_valid = 1'b1;
  endtask

  task automatic drive_rand();
    drive_set(N'($urandom), N'($urandom), N'($urandom), N'($urandom));
  endtask

  // Samples handshakes mid-cycle, keeps the scoreboard, returns 1 time unit after the next edge
  task automatic step();
    @(negedge clk);
    st_acc = bus.in_valid && bus.in_ready;
    if (st_acc) exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_c, bus.in_d));
    st_pop = bus.res_valid && bus.res_ready;
    st_got = bus.res_data;
    st_exp = 'x;
    if (st_pop && exp_q.size() > 0) st_exp = exp_q.pop_front();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.res_ready = 1'b0;
    drive_set('0, '0, '0, '0); bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b want=0", bus.in_ready); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got=%b want=0", bus.res_valid); end
    n_vec++; if (bus.res_data !== '0) begin n_err++; $display("FAIL rst_res_data got=%0d want=0", bus.res_data); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    n_vec++; if ({bus.p_a, bus.p_b, bus.p_c, bus.p_d} !== '0) begin n_err++; $display("FAIL rst_p_ops got=%h want=0", {bus.p_a, bus.p_b, bus.p_c, bus.p_d}); end
    n_vec++; if (int'(dut.r_credits) !== RDEPTH) begin n_err++; $display("FAIL rst_credits got=%0d want=%0d", dut.r_credits, RDEPTH); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got=%b want=1", bus.in_ready); end
    exp_q.delete();
  endtask

  task automatic test_single();
    int lat = -1;
    bus.res_ready = 1'b0;
    drive_set(10'd1, 10'd2, 10'd5, 10'd3);
    step();
    n_vec++; if (st_acc !== 1'b1) begin n_err++; $display("FAIL single_accept got=%b want=1", st_acc); end
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      step();
      if (k == 1) begin
        n_vec++; if ({bus.p_a, bus.p_b, bus.p_c, bus.p_d} !== {10'd1, 10'd2, 10'd5, 10'd3}) begin
          n_err++; $display("FAIL single_issue got=%h want=%h", {bus.p_a, bus.p_b, bus.p_c, bus.p_d}, {10'd1, 10'd2, 10'd5, 10'd3}); end
      end
      if (bus.res_valid) lat = k;
    end
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL single_latency got=%0d want=5", lat); end
    n_vec++; if (bus.res_data !== 10'd15) begin n_err++; $display("FAIL single_res_data got=%0d want=15", bus.res_data); end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    n_vec++; if (st_pop !== 1'b1 || st_got !== 10'd15) begin n_err++; $display("FAIL single_pop got=%b/%0d want=1/15", st_pop, st_got); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after_pop got=%b want=0", bus.busy); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] want [2];
    int got_n = 0;
    want[0] = 10'd1020;
    want[1] = 10'd1023;
    bus.res_ready = 1'b1;
    drive_set(10'd1023, 10'd1, 10'd0, 10'd2);
    step();
    n_vec++; if (st_acc !== 1'b1) begin n_err++; $display("FAIL wrap_accept0 got=%b want=1", st_acc); end
    drive_set(10'd0, 10'd0, 10'd0, 10'd1023);
    step();
    n_vec++; if (st_acc !== 1'b1) begin n_err++; $display("FAIL wrap_accept1 got=%b want=1", st_acc); end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 30 && got_n < 2; k++) begin
      step();
      if (st_pop) begin
        n_vec++; if (st_got !== want[got_n]) begin n_err++; $display("FAIL wrap_result%0d got=%0d want=%0d", got_n, st_got, want[got_n]); end
        n_vec++; if (st_got !== st_exp) begin n_err++; $display("FAIL wrap_scoreboard got=%0d want=%0d", st_got, st_exp); end
        got_n++;
      end
    end
    n_vec++; if (got_n !== 2) begin n_err++; $display("FAIL wrap_count got=%0d want=2", got_n); end
  endtask

  task automatic test_stream();
    int sent = 0;
    int pops = 0;
    bus.res_ready = 1'b1;
    drive_rand();
    for (int k = 0; k < 100 && pops < 16; k++) begin
      step();
      if (st_acc) begin sent++; if (sent < 16) drive_rand(); else bus.in_valid = 1'b0; end
      if (st_pop) begin
        pops++;
        n_vec++; if (st_got !== st_exp) begin n_err++; $display("FAIL stream_data got=%0d want=%0d", st_got, st_exp); end
      end
      n_vec++; if (int'(dut.r_credits) > RDEPTH) begin n_err++; $display("FAIL stream_credit_range got=%0d want<=%0d", dut.r_credits, RDEPTH); end
      n_vec++; if (int'(dut.r_credits) + $countones(dut.r_tag) + int'(dut.w_rcount) !== RDEPTH) begin
        n_err++; $display("FAIL stream_invariant credits=%0d tags=%b rcount=%0d want_sum=%0d", dut.r_credits, dut.r_tag, dut.w_rcount, RDEPTH); end
    end
    n_vec++; if (pops !== 16 || sent !== 16) begin n_err++; $display("FAIL stream_count got=%0d/%0d want=16/16", pops, sent); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int issues = 0;
    int pops = 0;
    bus.res_ready = 1'b0;
    drive_rand();
    for (int k = 0; k < 20; k++) begin
      step();
      if (dut.r_tag[0]) issues++;
      if (st_acc) begin
        acc++;
        if (acc == 8) begin
          n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_after8 got=%b want=0", bus.in_ready); end
        end
        if (acc < 10) drive_rand(); else bus.in_valid = 1'b0;
      end
    end
    n_vec++; if (issues !== RDEPTH) begin n_err++; $display("FAIL bp_issues got=%0d want=%0d", issues, RDEPTH); end
    n_vec++; if (acc !== 8) begin n_err++; $display("FAIL bp_accepts got=%0d want=8", acc); end
    n_vec++; if (bus.res_valid !== 1'b1 || int'(dut.r_credits) !== 0) begin
      n_err++; $display("FAIL bp_stalled got res_valid=%b credits=%0d want=1/0", bus.res_valid, dut.r_credits); end
    bus.res_ready = 1'b1;
    for (int k = 0; k < 100 && pops < 10; k++) begin
      step();
      if (st_acc) begin acc++; if (acc < 10) drive_rand(); else bus.in_valid = 1'b0; end
      if (st_pop) begin
        pops++;
        n_vec++; if (st_got !== st_exp) begin n_err++; $display("FAIL bp_drain_data got=%0d want=%0d", st_got, st_exp); end
      end
    end
    n_vec++; if (pops !== 10 || acc !== 10 || exp_q.size() != 0) begin
      n_err++; $display("FAIL bp_drain_count got pops=%0d acc=%0d left=%0d want=10/10/0", pops, acc, exp_q.size()); end
  endtask

  task automatic test_random();
    int acc = 0;
    int pops = 0;
    drive_rand();
    for (int k = 0; k < 4000 && pops < 200; k++) begin
      bus.res_ready = 1'($urandom_range(0, 1));
      step();
      if (st_acc) begin acc++; if (acc < 200) drive_rand(); else bus.in_valid = 1'b0; end
      if (st_pop) begin
        pops++;
        n_vec++; if (st_got !== st_exp) begin n_err++; $display("FAIL rand_data got=%0d want=%0d", st_got, st_exp); end
      end
      n_vec++; if (int'(dut.r_credits) + $countones(dut.r_tag) + int'(dut.w_rcount) !== RDEPTH) begin
        n_err++; $display("FAIL rand_invariant credits=%0d tags=%b rcount=%0d want_sum=%0d", dut.r_credits, dut.r_tag, dut.w_rcount, RDEPTH); end
    end
    n_vec++; if (pops !== 200 || exp_q.size() != 0) begin n_err++; $display("FAIL rand_count got=%0d left=%0d want=200/0", pops, exp_q.size()); end
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int got_n = 0;
    bus.res_ready = 1'b0;
    drive_rand();
    for (int k = 0; k < 40 && int'(dut.w_rcount) != 2; k++) begin
      step();
      if (st_acc) begin acc++; if (acc < 6) drive_rand(); else bus.in_valid = 1'b0; end
    end
    n_vec++; if (int'(dut.w_rcount) !== 2 || dut.r_tag === '0) begin
      n_err++; $display("FAIL mid_setup got rcount=%0d tags=%b want=2/nonzero", dut.w_rcount, dut.r_tag); end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    n_vec++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got res_valid=%b busy=%b want=0/0", bus.res_valid, bus.busy); end
    n_vec++; if (int'(dut.r_credits) !== RDEPTH) begin n_err++; $display("FAIL mid_credits got=%0d want=%0d", dut.r_credits, RDEPTH); end
    for (int k = 0; k < 8; k++) begin
      step();
      n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale_capture cycle=%0d got=%b want=0", k, bus.res_valid); end
    end
    bus.res_ready = 1'b1;
    drive_set(10'd2, 10'd2, 10'd2, 10'd2);
    for (int k = 0; k < 30 && got_n < 1; k++) begin
      step();
      if (st_acc) bus.in_valid = 1'b0;
      if (st_pop) begin
        got_n++;
        n_vec++; if (st_got !== 10'd8 || st_exp !== 10'd8) begin n_err++; $display("FAIL mid_new_set got=%0d model=%0d want=8", st_got, st_exp); end
      end
    end
    n_vec++; if (got_n !== 1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_new_count got=%0d busy=%b want=1/0", got_n, bus.busy); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
